// File: rtl/gecko_data_memory_responder.sv
// Word-wide data memory with byte-masked writes and in-order read responses.
// Latency: read accepted at edge N presents resp_valid/resp_data from edge N+1.
// Backpressure: req_ready drops once MAX_OUTSTANDING reads await a response pop.
module gecko_data_memory_responder #(
    parameter int ADDR_WIDTH      = 10,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_read_enable,
    input  logic [3:0]            req_write_mask,
    input  logic [31:0]           req_write_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data
);
    localparam int               PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [2:0]       MAX_CNT  = 3'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    logic [31:0]      mem [2**ADDR_WIDTH];
    logic [2:0]       outstanding;
    logic             req_fire;
    logic             rd_fire;
    logic             resp_fire;
    logic             p_vld;
    logic [31:0]      p_dat;
    logic [31:0]      fifo_dat [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [2:0]       count;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A pop in the same cycle frees a credit, so a full buffer can still accept.
    assign resp_fire  = resp_valid && resp_ready;
    assign req_ready  = !rst && ((outstanding < MAX_CNT) || resp_fire);
    assign req_fire   = req_valid && req_ready;
    assign rd_fire    = req_fire && req_read_enable;
    assign resp_valid = (count != 3'd0);
    assign resp_data  = fifo_dat[rd_ptr];

    // Read samples the array before this edge's byte writes land.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            if (req_read_enable) begin
                p_dat <= mem[req_addr];
            end
            for (int i = 0; i < 4; i++) begin
                if (req_write_mask[i]) begin
                    mem[req_addr][8*i +: 8] <= req_write_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= 3'd0;
            p_vld       <= 1'b0;
        end else begin
            p_vld <= rd_fire;
            if (rd_fire && !resp_fire) begin
                outstanding <= outstanding + 3'd1;
            end else if (!rd_fire && resp_fire) begin
                outstanding <= outstanding - 3'd1;
            end
        end
    end

    // Credits bound the pipeline stage plus buffer, so a push never finds it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_dat[i] <= 32'h0;
            end
        end else begin
            if (p_vld) begin
                fifo_dat[wr_ptr] <= p_dat;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (resp_fire) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + {2'b00, p_vld} - {2'b00, resp_fire};
        end
    end

`ifndef SYNTHESIS
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        outstanding <= MAX_CNT);
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_data)));
    a_resp_has_read: assert property (@(posedge clk) disable iff (rst)
        resp_valid |-> (outstanding != 3'd0));
`endif
endmodule

// File: tb/tb_gecko_data_memory_responder.sv
// Scoreboarded bench for gecko_data_memory_responder: reference memory model,
// expected read words queued on accept and compared on each response handshake.
module tb_gecko_data_memory_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic        req_read_enable;
    logic [3:0]  req_write_mask;
    logic [31:0] req_write_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;

    int          checks = 0;
    int          errors = 0;
    int          n_acc  = 0;
    int          n_resp = 0;
    logic        last_acc;
    logic        last_resp;
    logic [31:0] model [0:1023];
    logic [31:0] sb [$];

    gecko_data_memory_responder #(.ADDR_WIDTH(10), .MAX_OUTSTANDING(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_read_enable (req_read_enable),
        .req_write_mask  (req_write_mask),
        .req_write_data  (req_write_data),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data)
    );

    always #5 clk = ~clk;

    // Observe handshakes just after the falling edge, then advance one cycle.
    task automatic step();
        logic [31:0] exp;
        #1;
        last_resp = resp_valid && resp_ready;
        if (last_resp) begin
            n_resp++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected got %h required no response", resp_data);
            end else begin
                exp = sb.pop_front();
                if (resp_data !== exp) begin
                    errors++;
                    $display("FAIL resp_data got %h required %h", resp_data, exp);
                end
            end
        end
        last_acc = req_valid && req_ready && !rst;
        if (last_acc) begin
            n_acc++;
            if (req_read_enable) sb.push_back(model[req_addr]);
            for (int i = 0; i < 4; i++)
                if (req_write_mask[i]) model[req_addr][8*i +: 8] = req_write_data[8*i +: 8];
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [9:0] a, input logic re, input logic [3:0] m,
                         input logic [31:0] d, output int waited);
        req_valid = 1'b1; req_addr = a; req_read_enable = re;
        req_write_mask = m; req_write_data = d;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!last_acc && waited < 50);
        req_valid = 1'b0;
        checks++;
        if (!last_acc) begin
            errors++;
            $display("FAIL issue_timeout addr %0d got no accept required accept", a);
        end
    endtask

    task automatic drain();
        int n;
        resp_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending required 0", sb.size());
        end
        repeat (2) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_read_enable = 1'b0;
        req_write_mask = 4'h0; req_write_data = '0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h r=%b required v=0 d=0 r=0",
                     resp_valid, resp_data, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b required 1", req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_full_word();
        int w;
        resp_ready = 1'b1;
        issue(10'd5, 1'b0, 4'b1111, 32'h11223344, w);
        issue(10'd5, 1'b1, 4'b0000, 32'h0, w);
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got resp_valid=%b required 0", resp_valid);
        end
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h11223344) begin
            errors++;
            $display("FAIL latency_one got v=%b d=%h required v=1 d=11223344",
                     resp_valid, resp_data);
        end
        drain();
    endtask

    task automatic test_byte_mask();
        int w;
        resp_ready = 1'b1;
        issue(10'd7, 1'b0, 4'b1111, 32'h11223344, w);
        issue(10'd7, 1'b0, 4'b0100, 32'hABABABAB, w);
        issue(10'd7, 1'b1, 4'b0000, 32'h0, w);
        issue(10'd7, 1'b0, 4'b0011, 32'hCDEFCDEF, w);
        issue(10'd7, 1'b1, 4'b0000, 32'h0, w);
        issue(10'd7, 1'b0, 4'b0000, 32'hFFFFFFFF, w);
        issue(10'd7, 1'b1, 4'b0000, 32'h0, w);
        drain();
    endtask

    task automatic test_read_before_write();
        int w;
        resp_ready = 1'b1;
        issue(10'd3, 1'b0, 4'b1111, 32'hDEADBEEF, w);
        issue(10'd3, 1'b1, 4'b1111, 32'h00000000, w);
        issue(10'd3, 1'b1, 4'b0000, 32'h0, w);
        drain();
    endtask

    task automatic test_stall();
        int w;
        logic [31:0] held;
        resp_ready = 1'b1;
        issue(10'd1, 1'b0, 4'b1111, 32'h0101A001, w);
        issue(10'd2, 1'b0, 4'b1111, 32'h0202B002, w);
        repeat (2) step();
        resp_ready = 1'b0;
        issue(10'd1, 1'b1, 4'b0000, 32'h0, w);
        issue(10'd2, 1'b1, 4'b0000, 32'h0, w);
        req_valid = 1'b1; req_addr = 10'd3; req_read_enable = 1'b1; req_write_mask = 4'h0;
        held = resp_data;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready cycle %0d got %b required 0", k, req_ready);
            end
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== held || held !== 32'h0101A001) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got v=%b d=%h required v=1 d=0101a001",
                         k, resp_valid, resp_data);
            end
            step();
        end
        resp_ready = 1'b1;
        w = 0;
        do begin
            step();
            w++;
        end while (!last_acc && w < 20);
        req_valid = 1'b0;
        checks++;
        if (!last_acc) begin
            errors++;
            $display("FAIL stall_release got no accept required accept of addr 3");
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int w, first, last, acc_miss, resp0;
        resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) issue(10'(i), 1'b0, 4'b1111, 32'hA5000000 | i, w);
        repeat (2) step();
        first = -1; last = -1; acc_miss = 0; resp0 = n_resp;
        for (int i = 0; i < 24; i++) begin
            if (i < 16) begin
                req_valid = 1'b1; req_addr = 10'(i); req_read_enable = 1'b1; req_write_mask = 4'h0;
            end else begin
                req_valid = 1'b0;
            end
            step();
            if (i < 16 && !last_acc) acc_miss++;
            if (last_resp) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        checks++;
        if (acc_miss != 0) begin
            errors++;
            $display("FAIL b2b_accepts got %0d missed required 0", acc_miss);
        end
        checks++;
        if (first != 2 || last != 17 || n_resp - resp0 != 16) begin
            errors++;
            $display("FAIL b2b_gapless got first=%0d last=%0d n=%0d required 2 17 16",
                     first, last, n_resp - resp0);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int w, resp0;
        resp_ready = 1'b1;
        issue(10'd9,  1'b0, 4'b1111, 32'hCAFEF00D, w);
        issue(10'd10, 1'b0, 4'b1111, 32'h12345678, w);
        resp_ready = 1'b0;
        issue(10'd9,  1'b1, 4'b0000, 32'h0, w);
        issue(10'd10, 1'b1, 4'b0000, 32'h0, w);
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0 || resp_data !== 32'h0) begin
            errors++;
            $display("FAIL midreset_state got v=%b r=%b d=%h required 0 0 0",
                     resp_valid, req_ready, resp_data);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        resp_ready = 1'b1;
        resp0 = n_resp;
        repeat (4) step();
        checks++;
        if (n_resp != resp0) begin
            errors++;
            $display("FAIL midreset_no_resp got %0d responses required 0", n_resp - resp0);
        end
        resp_ready = 1'b0;
        issue(10'd9, 1'b1, 4'b0000, 32'h0, w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL midreset_credit0 got wait %0d required 1", w);
        end
        issue(10'd10, 1'b1, 4'b0000, 32'h0, w);
        checks++;
        if (w != 1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_credit_full got wait %0d ready %b required 1 0", w, req_ready);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_byte_mask();
        test_read_before_write();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
